// File: rtl/sobel_window_gen.sv
// sobel_window_gen
// Raster-to-window front end for the Sobel pipeline. Takes one gray+RGB pixel
// per handshake and emits, per pixel, the 3x3 gray neighbourhood centred on it,
// the centre pixel's RGB, a border flag and an end-of-frame marker. After the
// last input pixel of a frame it pushes IMG_W+1 zero pixels by itself so the
// final line of windows drains without waiting for the next frame.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   pix_gray/pix_rgb   incoming raster pixel (gray 8b, RGB 24b)
//   pix_valid/ready    input handshake (ready is 0 while flushing)
//   a11..a33           window taps, row 1 = line above, column 1 = left
//   data_m_rgb         RGB of window centre
//   zero_valid         centre lies on the image border
//   eof_m              beat carries the last centre pixel of the frame
//   valid_m/ready_m    output handshake
//
// state | meaning
// RUN   | accepting raster pixels from the input
// FLUSH | input blocked, pushing IMG_W+1 zero pixels to drain the last line
module sobel_window_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  pix_gray,
  input  logic [23:0] pix_rgb,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  a11,
  output logic [7:0]  a12,
  output logic [7:0]  a13,
  output logic [7:0]  a21,
  output logic [7:0]  a22,
  output logic [7:0]  a23,
  output logic [7:0]  a31,
  output logic [7:0]  a32,
  output logic [7:0]  a33,
  output logic [23:0] data_m_rgb,
  output logic        zero_valid,
  output logic        eof_m,
  output logic        valid_m,
  input  logic        ready_m
);

  localparam int NW = $clog2(IMG_W*IMG_H + IMG_W + 1);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [NW-1:0] N_FILL    = NW'(IMG_W + 1);
  localparam logic [NW-1:0] N_LAST_IN = NW'(IMG_W*IMG_H - 1);
  localparam logic [NW-1:0] N_END     = NW'(IMG_W*IMG_H + IMG_W);
  localparam logic [CW-1:0] C_LAST    = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST    = RW'(IMG_H - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state;
  logic [NW-1:0] n;
  logic [CW-1:0] wcol;   // line-buffer column of the pixel being pushed
  logic [CW-1:0] cc;     // centre column of the next output
  logic [RW-1:0] cr;     // centre row of the next output

  logic [7:0]  lb0 [IMG_W];   // previous line (pixel n-IMG_W at column wcol)
  logic [7:0]  lb1 [IMG_W];   // line before that (pixel n-2*IMG_W)
  logic [23:0] rgb_lb [IMG_W];
  logic [23:0] rgb_d;

  // Columns of the two most recently pushed pixels; a = n-1, b = n-2.
  // Row 0 is the top line of the window.
  logic [7:0] ca0, ca1, ca2, cb0, cb1, cb2;

  logic        adv;
  logic [7:0]  in_gray;
  logic [23:0] in_rgb;
  logic [7:0]  lb0_rd, lb1_rd;
  logic [23:0] rgb_rd;
  logic        top, bot, lft, rgt;

  always_comb begin
    pix_ready = (state == RUN) && (!valid_m || ready_m);
    adv       = (!valid_m || ready_m) && ((state == FLUSH) || pix_valid);
    in_gray   = (state == FLUSH) ? 8'd0  : pix_gray;
    in_rgb    = (state == FLUSH) ? 24'd0 : pix_rgb;
    lb0_rd    = lb0[wcol];
    lb1_rd    = lb1[wcol];
    rgb_rd    = rgb_lb[wcol];
    top       = (cr == '0);
    bot       = (cr == R_LAST);
    lft       = (cc == '0);
    rgt       = (cc == C_LAST);
  end

  // Buffers are deliberately unreset: every stale or uninitialised entry
  // only ever lands on a tap that the border masking forces to zero.
  always_ff @(posedge clk) begin
    if (adv) begin
      lb0[wcol]    <= in_gray;
      lb1[wcol]    <= lb0_rd;
      rgb_lb[wcol] <= in_rgb;
      cb0   <= ca0;
      cb1   <= ca1;
      cb2   <= ca2;
      ca0   <= lb1_rd;
      ca1   <= lb0_rd;
      ca2   <= in_gray;
      rgb_d <= rgb_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      n          <= '0;
      wcol       <= '0;
      cc         <= '0;
      cr         <= '0;
      valid_m    <= 1'b0;
      a11 <= '0; a12 <= '0; a13 <= '0;
      a21 <= '0; a22 <= '0; a23 <= '0;
      a31 <= '0; a32 <= '0; a33 <= '0;
      data_m_rgb <= '0;
      zero_valid <= 1'b0;
      eof_m      <= 1'b0;
    end else if (adv) begin
      wcol <= (wcol == C_LAST) ? '0 : wcol + CW'(1);
      if (n >= N_FILL) begin
        // Window after this shift: column 3 is the new pixel and the two
        // line-buffer reads, columns 2/1 are the held columns a/b.
        a11 <= (top || lft) ? 8'd0 : cb0;
        a12 <= top          ? 8'd0 : ca0;
        a13 <= (top || rgt) ? 8'd0 : lb1_rd;
        a21 <= lft          ? 8'd0 : cb1;
        a22 <= ca1;
        a23 <= rgt          ? 8'd0 : lb0_rd;
        a31 <= (bot || lft) ? 8'd0 : cb2;
        a32 <= bot          ? 8'd0 : ca2;
        a33 <= (bot || rgt) ? 8'd0 : in_gray;
        data_m_rgb <= rgb_d;
        zero_valid <= top || bot || lft || rgt;
        eof_m      <= bot && rgt;
        valid_m    <= 1'b1;
        cc <= rgt ? '0 : cc + CW'(1);
        if (rgt) cr <= bot ? '0 : cr + RW'(1);
      end else if (ready_m) begin
        valid_m <= 1'b0;
      end
      case (state)
        RUN: begin
          n <= n + NW'(1);
          if (n == N_LAST_IN) state <= FLUSH;
        end
        FLUSH: begin
          if (n == N_END) begin
            n     <= '0;
            wcol  <= '0;
            state <= RUN;
          end else begin
            n <= n + NW'(1);
          end
        end
        default: state <= RUN;
      endcase
    end else if (ready_m) begin
      valid_m <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Testbench for sobel_window_gen on a 4x3 image: stimulus drives frames and
// pushes the expected beats of each frame into a queue; a monitor pops and
// compares every beat the DUT hands over.
module tb_sobel_window_gen;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pix_gray = '0;
  logic [23:0] pix_rgb = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  a11, a12, a13, a21, a22, a23, a31, a32, a33;
  logic [23:0] data_m_rgb;
  logic        zero_valid, eof_m, valid_m;
  logic        ready_m = 1'b1;

  always #5 clk = ~clk;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .pix_gray(pix_gray), .pix_rgb(pix_rgb), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .a11(a11), .a12(a12), .a13(a13), .a21(a21), .a22(a22), .a23(a23),
    .a31(a31), .a32(a32), .a33(a33),
    .data_m_rgb(data_m_rgb), .zero_valid(zero_valid), .eof_m(eof_m),
    .valid_m(valid_m), .ready_m(ready_m)
  );

  typedef struct packed {
    logic [71:0] taps;
    logic [23:0] rgb;
    logic        zv;
    logic        eof;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    beats  = 0;
  logic  discard = 1'b0;
  int    fg[NPIX];
  int    frgb[NPIX];

  // Expected beat for centre k straight from the image: neighbours outside
  // the image read as zero.
  function automatic beat_t model(int k);
    beat_t b;
    int r, c, rr, cc, v, i;
    r = k / W;
    c = k % W;
    b.taps = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        rr = r + dr;
        cc = c + dc;
        v  = (rr >= 0 && rr < H && cc >= 0 && cc < W) ? fg[rr*W + cc] : 0;
        i  = (dr + 1) * 3 + (dc + 1);
        b.taps[(8-i)*8 +: 8] = 8'(v);
      end
    end
    b.rgb = 24'(frgb[k]);
    b.zv  = (r == 0) || (r == H-1) || (c == 0) || (c == W-1);
    b.eof = (k == NPIX-1);
    return b;
  endfunction

  function automatic beat_t dut_beat();
    beat_t b;
    b.taps = {a11, a12, a13, a21, a22, a23, a31, a32, a33};
    b.rgb  = data_m_rgb;
    b.zv   = zero_valid;
    b.eof  = eof_m;
    return b;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: compares each transferred beat with the queue head, and checks
  // that a stalled beat stays put with the input blocked.
  beat_t held;
  logic  held_v = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && valid_m) begin
        if (!ready_m) begin
          chk("stall_pix_ready", 128'(pix_ready), 128'(0));
          if (held_v) chk("stall_hold", 128'(dut_beat()), 128'(held));
          held   = dut_beat();
          held_v = 1'b1;
        end else begin
          held_v = 1'b0;
          if (!discard) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL spurious_beat: got %h expected none", dut_beat());
            end else begin
              chk($sformatf("beat%0d", beats % NPIX), 128'(dut_beat()), 128'(exp_q.pop_front()));
              beats++;
            end
          end
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic drive_pixel(input int g, input int rgb, input bit rand_idle, output bit ok);
    int t;
    ok = 1'b1;
    if (rand_idle) begin
      for (int j = 0; j < 3; j++) begin
        if ($urandom_range(0, 1) == 0) break;
        pix_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    pix_valid = 1'b1;
    pix_gray  = 8'(g);
    pix_rgb   = 24'(rgb);
    t = 0;
    forever begin
      @(negedge clk);
      if (pix_ready) break;
      t++;
      if (t > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no pix_ready expected accept within 200 cycles");
        ok = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic run_frame(input int gmode, input bit rand_valid);
    bit ok;
    int t;
    for (int k = 0; k < NPIX; k++) begin
      fg[k]   = (gmode == 0) ? k : int'($urandom_range(0, 255));
      frgb[k] = (gmode == 0) ? (32'h100000 + k) : int'($urandom_range(0, 32'hFFFFFF));
    end
    for (int k = 0; k < NPIX; k++) exp_q.push_back(model(k));
    for (int k = 0; k < NPIX; k++) begin
      drive_pixel(fg[k], frgb[k], rand_valid, ok);
      if (!ok) return;
    end
    // Flushing: input must be blocked until the last beat is presented.
    t = 0;
    forever begin
      @(negedge clk);
      if (valid_m && eof_m) break;
      chk("flush_pix_ready", 128'(pix_ready), 128'(0));
      t++;
      if (t > 100) begin
        checks++;
        errors++;
        $display("FAIL flush_timeout: got no eof beat expected within 100 cycles");
        break;
      end
    end
    if (ready_m) chk("post_flush_ready", 128'(pix_ready), 128'(1));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic do_reset();
    pix_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid_m", 128'(valid_m), 128'(0));
    chk("rst_taps", 128'({a11, a12, a13, a21, a22, a23, a31, a32, a33}), 128'(0));
    chk("rst_rgb", 128'(data_m_rgb), 128'(0));
    chk("rst_eof_zv", 128'({eof_m, zero_valid}), 128'(0));
    chk("rst_pix_ready", 128'(pix_ready), 128'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Index stream, downstream always ready.
    run_frame(0, 1'b0);
    drain();

    // Same stream with a 10-cycle downstream stall and ragged input.
    fork
      begin
        repeat (12) @(posedge clk);
        #1 ready_m = 1'b0;
        repeat (10) @(posedge clk);
        #1 ready_m = 1'b1;
      end
    join_none
    run_frame(0, 1'b1);
    drain();

    // Two random frames back to back.
    run_frame(1, 1'b0);
    run_frame(1, 1'b0);
    drain();

    // Random frame under random backpressure.
    fork
      begin
        repeat (80) begin
          @(posedge clk);
          #1 ready_m = 1'($urandom_range(0, 1));
        end
        ready_m = 1'b1;
      end
    join_none
    run_frame(1, 1'b1);
    drain();
    wait (ready_m == 1'b1);
    @(posedge clk); #1;

    // Partial frame abandoned by reset, then a clean index frame.
    discard = 1'b1;
    for (int k = 0; k < 7; k++) begin
      drive_pixel(200 + k, k, 1'b0, ok);
    end
    do_reset();
    discard = 1'b0;
    run_frame(0, 1'b0);
    drain();

    chk("beat_total", 128'(beats), 128'(6 * NPIX));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Raster-to-window front end for the Sobel pipeline.
- Accepts one pixel per handshake: an 8-bit gray value plus its 24-bit RGB.
- Emits one 3x3 gray neighbourhood per pixel on a1x..a3x, together with the centre pixel's RGB and a border flag (zero_valid). This is exactly the master side the Sobel pipeline consumes.
- Uses two gray line buffers and one RGB delay line, and self-flushes at end of frame.

Parameters:
IMG_W  640  pixels per line, >= 3
IMG_H  480  lines per frame, >= 3

Ports:
clk         input   1   clock
rst_n       input   1   synchronous active-low reset
pix_gray    input   8   gray value of incoming raster pixel
pix_rgb     input   24  RGB of incoming pixel
pix_valid   input   1   input pixel valid
pix_ready   output  1   input pixel accepted when pix_valid & pix_ready
a11..a33    output  8   nine window taps; row 1 = line above, column 1 = left of centre
data_m_rgb  output  24  RGB of window centre pixel
zero_valid  output  1   centre lies on the image border
eof_m       output  1   beat carries the last centre pixel of the frame
valid_m     output  1   output beat valid
ready_m     input   1   downstream ready

Behaviour:
- Single clock domain on clk. Reset is synchronous, active-low, sampled on the clk rising edge. During reset all registered outputs are 0 (taps, data_m_rgb, zero_valid, eof_m, valid_m), counters are 0, and the state is RUN.
- Line buffer contents are not reset and are never read uninitialised; border taps are forced to 0.
- Shift event: fires when adv = (!valid_m | ready_m) & (state==FLUSH | pix_valid).
  - In RUN, pix_ready = !valid_m | ready_m, which is combinational from ready_m. In FLUSH, pix_ready = 0.
  - Each shift pushes one pixel into the window and line buffers: the accepted input in RUN, or gray=0/RGB=0 in FLUSH.
- Shift counter n runs 0 .. IMG_W*IMG_H+IMG_W, restarting at 0 each frame. The newest pushed pixel is a33. The centre index is k = n-(IMG_W+1), with r = k/IMG_W and c = k%IMG_W.
  - Shifts with n < IMG_W+1 produce no output (fill).
  - Every shift with n >= IMG_W+1 loads the output register and sets valid_m=1 on the next edge.
  - valid_m clears on ready_m & valid_m when no new shift occurs in the same cycle.
  - Latency: the first output appears IMG_W+1 accepted pixels after frame start, registered one cycle later.
- Out-of-image taps are forced to 0:
  - r==0: a11,a12,a13 = 0
  - r==IMG_H-1: a31,a32,a33 = 0
  - c==0: a11,a21,a31 = 0
  - c==IMG_W-1: a13,a23,a33 = 0
  - This masking also covers wrap-around from the previous line, since line buffers are indexed by column.
- zero_valid = (r==0)|(r==IMG_H-1)|(c==0)|(c==IMG_W-1). data_m_rgb = RGB of pixel k, taken from an RGB delay line of depth IMG_W+1.
- eof_m = 1 only on the beat with k == IMG_W*IMG_H-1.
- State machine:
  - RUN→FLUSH when the input with n == IMG_W*IMG_H-1 is accepted.
  - FLUSH performs exactly IMG_W+1 internal shifts, each gated by adv (so backpressure stalls the flush).
  - FLUSH→RUN, with n=0, on the last flush shift. The next frame's first pixel can be accepted in the following cycle.
- Output hold: while valid_m & !ready_m, every output is stable and no shift occurs. No beat is dropped or duplicated.
- Simultaneous events: a ready_m acceptance and a new shift in the same cycle replace the beat with no bubble, giving a full-throughput 1 beat/cycle.
- Reset mid-frame discards the partial frame. The next accepted pixel is treated as the frame's pixel 0.
- Widths: counters are $clog2(IMG_W*IMG_H+IMG_W+1) bits; column and row counters are $clog2(IMG_W) and $clog2(IMG_H) bits, wrapping at IMG_W-1 and IMG_H-1.

Test Plan:
1. Reset → valid_m=0, all taps and data_m_rgb =0, eof_m=0; pix_ready=1 in the first cycle after reset release.
2. IMG_W=4, IMG_H=3, pix_gray=pixel index 0..11, pix_rgb=0x100000+index, ready_m=1:
   - No valid_m before the 5th pixel is accepted; exactly 12 beats follow.
   - Beat 0: a22=0, a23=1, a32=4, a33=5, other taps 0, zero_valid=1.
   - Beat 5: a11..a33 = 0,1,2,4,5,6,8,9,10, zero_valid=0, data_m_rgb=0x100005.
   - Beat 6: zero_valid=0; all other beats: zero_valid=1.
3. Same stream with ready_m=0 for 10 cycles mid-frame and pix_valid toggling randomly → outputs frozen while stalled; pix_ready=0 while stalled; beat sequence identical to scenario 2.
4. End of frame: after pixel 11 is accepted, pix_ready=0 for the 5 flush shifts → beats 7..11 emitted; eof_m=1 only on beat 11 (a11=6, a12=7, a21=10, a22=11, others 0); then pix_ready=1.
5. Two back-to-back frames with pix_valid=1 and ready_m=1 → 24 beats; frame-2 beat 0 taps contain no frame-1 data; eof_m pulses twice.
6. rst_n=0 for 1 cycle after 7 pixels, then a full frame → exactly 12 beats, matching scenario 2.
